// File: rtl/sphere_scene_loader.sv
// Double-buffered sphere table loader: header + N sphere words fill the shadow bank,
// swapped in on frame_start. Optional checksum trailer enabled by LOADER_CHECKSUM_EN.
module sphere_scene_loader #(
  parameter int unsigned N_SPHERES = 4,
  parameter int unsigned WORD_W    = 64,
  localparam int unsigned IdxW     = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              ck_rst,
  input  logic              recv_dv,
  input  logic [WORD_W-1:0] recv_64bit,
  input  logic              frame_start,
  input  logic [IdxW-1:0]   rd_index,
  output logic [WORD_W-1:0] rd_sphere,
  output logic [7:0]        sphere_count,
  output logic              scene_valid,
  output logic              recv_interrupt,
  output logic              err_header,
  output logic              err_drop
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StPending, StCheck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StPending} state_e;
`endif

  state_e            state_q;
  logic              act_sel_q, act_sel_d;
  logic [7:0]        wr_ptr_q, count_q, sphere_count_q;
  logic              scene_valid_q, err_header_q, err_drop_q;
  logic [WORD_W-1:0] rd_sphere_q;
  logic [WORD_W-1:0] mem_q [2][N_SPHERES];
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;
`endif

  logic [7:0] hdr_count, wr_ptr_inc;
  logic       hdr_ok, swap;

  always_comb begin
    hdr_count  = recv_64bit[7:0];
    hdr_ok     = (recv_64bit[63:56] == 8'hA5) && (hdr_count != 8'd0) &&
                 ({24'd0, hdr_count} <= N_SPHERES);
    wr_ptr_inc = wr_ptr_q + 8'd1;
    swap       = (state_q == StPending) && frame_start;
    act_sel_d  = act_sel_q ^ swap;
  end

  // Shadow bank is the one not selected; contents survive reset by design.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst && (state_q == StLoad) && recv_dv) begin
      mem_q[~act_sel_q][wr_ptr_q[IdxW-1:0]] <= recv_64bit;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state_q        <= StIdle;
      act_sel_q      <= 1'b0;
      wr_ptr_q       <= 8'd0;
      count_q        <= 8'd0;
      sphere_count_q <= 8'd0;
      scene_valid_q  <= 1'b0;
      err_header_q   <= 1'b0;
      err_drop_q     <= 1'b0;
      rd_sphere_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      err_header_q <= 1'b0;
      err_drop_q   <= 1'b0;
      act_sel_q    <= act_sel_d;
      // Read through the next select so a swap is visible right after its edge.
      rd_sphere_q  <= mem_q[act_sel_d][rd_index];
      case (state_q)
        StIdle: begin
          if (recv_dv) begin
            if (hdr_ok) begin
              count_q  <= hdr_count;
              wr_ptr_q <= 8'd0;
              state_q  <= StLoad;
`ifdef LOADER_CHECKSUM_EN
              csum_q   <= recv_64bit;
`endif
            end else begin
              err_header_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (recv_dv) begin
            wr_ptr_q <= wr_ptr_inc;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ recv_64bit;
            if (wr_ptr_inc == count_q) state_q <= StCheck;
`else
            if (wr_ptr_inc == count_q) state_q <= StPending;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (recv_dv) begin
            if (recv_64bit == csum_q) begin
              state_q <= StPending;
            end else begin
              err_drop_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end
`endif
        StPending: begin
          if (recv_dv) err_drop_q <= 1'b1;
          if (frame_start) begin
            sphere_count_q <= count_q;
            scene_valid_q  <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_sphere      = rd_sphere_q;
  assign sphere_count   = sphere_count_q;
  assign scene_valid    = scene_valid_q;
  assign recv_interrupt = (state_q == StIdle);
  assign err_header     = err_header_q;
  assign err_drop       = err_drop_q;

endmodule

// File: tb/tb_sphere_scene_loader.sv
// Directed bench for sphere_scene_loader; checksum steps compile in with LOADER_CHECKSUM_EN.
module tb_sphere_scene_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [63:0] word = '0;
  logic        fs = 1'b0;
  logic [1:0]  idx = 2'd0;
  logic [63:0] rd;
  logic [7:0]  cnt;
  logic        valid, irq, eh, ed;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] S0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] S1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] T0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] T1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] T2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] XW = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] U0 = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] V0 = 64'h1234_1234_1234_1234;
  localparam logic [63:0] W0 = 64'hCAFE_F00D_CAFE_F00D;
  localparam logic [63:0] H1 = 64'hA500_0000_0000_0001;
  localparam logic [63:0] H2 = 64'hA500_0000_0000_0002;
  localparam logic [63:0] H3 = 64'hA500_0000_0000_0003;

  sphere_scene_loader #(.N_SPHERES(4), .WORD_W(64)) dut (
    .CLK100MHZ     (clk),
    .ck_rst        (rst),
    .recv_dv       (dv),
    .recv_64bit    (word),
    .frame_start   (fs),
    .rd_index      (idx),
    .rd_sphere     (rd),
    .sphere_count  (cnt),
    .scene_valid   (valid),
    .recv_interrupt(irq),
    .err_header    (eh),
    .err_drop      (ed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    dv   = 1'b1;
    word = w;
    step();
    dv   = 1'b0;
  endtask

  task automatic frame();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  // Checksum trailer only exists when the feature is compiled in.
  task automatic trailer(input logic [63:0] w);
`ifdef LOADER_CHECKSUM_EN
    send(w);
`else
    if (w === 64'hx) $display("unused trailer");
`endif
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_rd", rd, 64'd0);
    chk("rst_irq", 64'(irq), 64'd1);
    chk("rst_eh", 64'(eh), 64'd0);
    chk("rst_ed", 64'(ed), 64'd0);
    rst = 1'b0;
    step();

    // Nominal load and swap
    send(H2);
    chk("nom_irq_hdr", 64'(irq), 64'd0);
    send(S0);
    chk("nom_irq_s0", 64'(irq), 64'd0);
    send(S1);
    trailer(H2 ^ S0 ^ S1);
    chk("nom_irq_pend", 64'(irq), 64'd0);
    chk("nom_valid_pend", 64'(valid), 64'd0);
    frame();
    chk("nom_irq_swap", 64'(irq), 64'd1);
    chk("nom_count", 64'(cnt), 64'd2);
    chk("nom_valid", 64'(valid), 64'd1);
    chk("nom_rd0_newbank", rd, S0);
    idx = 2'd1;
    step();
    chk("nom_rd1", rd, S1);

    // Bad headers
    send(64'h5A00_0000_0000_0002);
    chk("badmagic_eh", 64'(eh), 64'd1);
    chk("badmagic_irq", 64'(irq), 64'd1);
    step();
    chk("eh_one_cycle", 64'(eh), 64'd0);
    send(64'hA500_0000_0000_0005);
    chk("badcount_eh", 64'(eh), 64'd1);
    chk("badcount_irq", 64'(irq), 64'd1);
    step();
    chk("bad_rd_kept", rd, S1);
    chk("bad_count_kept", 64'(cnt), 64'd2);

    // No mid-load swap, overflow drop
    send(H3);
    send(T0);
    frame();
    chk("midload_count", 64'(cnt), 64'd2);
    chk("midload_irq", 64'(irq), 64'd0);
    send(T1);
    send(T2);
    trailer(H3 ^ T0 ^ T1 ^ T2);
    chk("pend_ed_quiet", 64'(ed), 64'd0);
    send(XW);
    chk("overflow_ed", 64'(ed), 64'd1);
    chk("overflow_rd_old", rd, S1);
    chk("overflow_count_old", 64'(cnt), 64'd2);
    frame();
    chk("ovf_swap_count", 64'(cnt), 64'd3);
    chk("ovf_swap_irq", 64'(irq), 64'd1);
    chk("ovf_swap_rd1", rd, T1);
    idx = 2'd2;
    step();
    chk("ovf_rd2", rd, T2);

    // Last word together with frame_start
    send(H1);
    dv = 1'b1; word = U0; fs = 1'b1;
    step();
    dv = 1'b0; fs = 1'b0;
    trailer(H1 ^ U0);
    chk("sim_irq", 64'(irq), 64'd0);
    chk("sim_noswap", 64'(cnt), 64'd3);
    idx = 2'd0;
    frame();
    chk("sim_swap_count", 64'(cnt), 64'd1);
    chk("sim_swap_rd", rd, U0);

    // Reset mid-load, with a concurrent header strobe
    send(H2);
    send(V0);
    rst = 1'b1; dv = 1'b1; word = H1; fs = 1'b1;
    step();
    dv = 1'b0; fs = 1'b0;
    chk("midrst_irq", 64'(irq), 64'd1);
    chk("midrst_count", 64'(cnt), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_rd", rd, 64'd0);
    rst = 1'b0;
    step();
    send(H1);
    send(W0);
    trailer(H1 ^ W0);
    frame();
    chk("postrst_count", 64'(cnt), 64'd1);
    chk("postrst_valid", 64'(valid), 64'd1);
    chk("postrst_rd", rd, W0);

`ifdef LOADER_CHECKSUM_EN
    send(H1);
    send(T0);
    send(H1 ^ T0);
    frame();
    chk("csum_ok_rd", rd, T0);
    chk("csum_ok_irq", 64'(irq), 64'd1);
    send(H1);
    send(T1);
    send(H1 ^ T1 ^ 64'd1);
    chk("csum_bad_ed", 64'(ed), 64'd1);
    chk("csum_bad_irq", 64'(irq), 64'd1);
    frame();
    chk("csum_bad_noswap", rd, T0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
